// File: rtl/tick_sequencer.sv
// Scheduled tick-period sequencer: walks a small period table with a
// single down-counter, pulsing on each entry expiry.
module tick_sequencer #(
  parameter int DEPTH = 4,
  parameter int PW    = 4,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_en,
  input  logic          start,
  input  logic          stop,
  input  logic          pause,
  input  logic          loop_en,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_addr,
  input  logic [PW-1:0] cfg_data,
  input  logic [IW-1:0] cfg_last,
  output logic          busy,
  output logic          paused,
  output logic [IW-1:0] cur_index,
  output logic [PW:0]   remaining,
  output logic          out_pulse,
  output logic          seq_done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_t;

  state_t        state;
  logic [PW-1:0] tbl [DEPTH];
  logic [IW-1:0] nxt_idx;

  localparam logic [PW:0] ONE = (PW+1)'(1);

  // A stored zero stands for the full 2^PW period.
  function automatic logic [PW:0] ld(input logic [PW-1:0] p);
    ld = (p == '0) ? {1'b1, {PW{1'b0}}} : {1'b0, p};
  endfunction

  assign nxt_idx = cur_index + IW'(1);
  assign busy    = (state != IDLE);
  assign paused  = (state == PAUSE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_index <= '0;
      remaining <= '0;
      out_pulse <= 1'b0;
      seq_done  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= '0;
      end
    end else begin
      out_pulse <= 1'b0;
      seq_done  <= 1'b0;
      // Loads below read the pre-write table contents.
      if (cfg_we) begin
        tbl[cfg_addr] <= cfg_data;
      end
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state     <= RUN;
            cur_index <= '0;
            remaining <= ld(tbl[0]);
          end
        end
        RUN: begin
          if (stop) begin
            state     <= IDLE;
            cur_index <= '0;
            remaining <= '0;
          end else if (pause) begin
            state <= PAUSE;
          end else if (tick_en) begin
            if (remaining > ONE) begin
              remaining <= remaining - ONE;
            end else begin
              out_pulse <= 1'b1;
              if (cur_index < cfg_last) begin
                cur_index <= nxt_idx;
                remaining <= ld(tbl[nxt_idx]);
              end else if (loop_en) begin
                cur_index <= '0;
                remaining <= ld(tbl[0]);
              end else begin
                state     <= IDLE;
                seq_done  <= 1'b1;
                remaining <= '0;
              end
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            state     <= IDLE;
            cur_index <= '0;
            remaining <= '0;
          end else if (!pause) begin
            state <= RUN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tick_sequencer.sv
// Bench for tick_sequencer: per-cycle model compare plus directed
// scenarios with literal pulse timings.
module tb_tick_sequencer;

  localparam int DEPTH = 4;
  localparam int PW    = 4;
  localparam int IW    = 2;

  logic          clk;
  logic          reset;
  logic          tick_en;
  logic          start;
  logic          stop;
  logic          pause;
  logic          loop_en;
  logic          cfg_we;
  logic [IW-1:0] cfg_addr;
  logic [PW-1:0] cfg_data;
  logic [IW-1:0] cfg_last;
  logic          busy;
  logic          paused;
  logic [IW-1:0] cur_index;
  logic [PW:0]   remaining;
  logic          out_pulse;
  logic          seq_done;

  tick_sequencer #(.DEPTH(DEPTH), .PW(PW)) dut (
    .clk(clk),
    .reset(reset),
    .tick_en(tick_en),
    .start(start),
    .stop(stop),
    .pause(pause),
    .loop_en(loop_en),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_last(cfg_last),
    .busy(busy),
    .paused(paused),
    .cur_index(cur_index),
    .remaining(remaining),
    .out_pulse(out_pulse),
    .seq_done(seq_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int pulse_q[$];
  int done_q[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d want %0d", nm, cyc, act, exp);
    end
  endtask

  // Model: mode 0 idle, 1 counting, 2 frozen.
  int m_mode = 0;
  int m_idx = 0;
  int m_left = 0;
  int m_pulse = 0;
  int m_done = 0;
  int m_tbl[DEPTH];

  function automatic int ldm(input int p);
    return (p == 0) ? (1 << PW) : p;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      m_mode = 0; m_idx = 0; m_left = 0;
      m_pulse = 0; m_done = 0;
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = 0;
    end else begin
      m_pulse = 0;
      m_done = 0;
      if (m_mode == 0) begin
        if (start && !stop) begin
          m_mode = 1; m_idx = 0; m_left = ldm(m_tbl[0]);
        end
      end else if (stop) begin
        m_mode = 0; m_idx = 0; m_left = 0;
      end else if (m_mode == 2) begin
        if (!pause) m_mode = 1;
      end else if (pause) begin
        m_mode = 2;
      end else if (tick_en) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_pulse = 1;
          if (m_idx < int'(cfg_last)) begin
            m_idx = m_idx + 1;
            m_left = ldm(m_tbl[m_idx]);
          end else if (loop_en) begin
            m_idx = 0;
            m_left = ldm(m_tbl[0]);
          end else begin
            m_mode = 0; m_done = 1; m_left = 0;
          end
        end
      end
      if (cfg_we) m_tbl[cfg_addr] = int'(cfg_data);
    end
  end

  always @(posedge clk) begin
    #1;
    chk("busy", busy, (m_mode != 0) ? 1 : 0);
    chk("paused", paused, (m_mode == 2) ? 1 : 0);
    chk("cur_index", cur_index, m_idx);
    chk("remaining", remaining, m_left);
    chk("out_pulse", out_pulse, m_pulse);
    chk("seq_done", seq_done, m_done);
    if (out_pulse === 1'b1) pulse_q.push_back(cyc - start_cyc);
    if (seq_done === 1'b1) done_q.push_back(cyc - start_cyc);
  end

  task automatic cfg(input logic [IW-1:0] a, input logic [PW-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    start_cyc = cyc + 1;
    pulse_q.delete();
    done_q.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int pq(input int i);
    return (pulse_q.size() > i) ? pulse_q[i] : -1;
  endfunction

  initial begin
    reset = 1'b1; tick_en = 1'b0; start = 1'b0; stop = 1'b0;
    pause = 1'b0; loop_en = 1'b0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; cfg_last = '0;
    wait_n(2);
    chk("rst_busy", busy, 0);
    chk("rst_rem", remaining, 0);
    chk("rst_pulse", out_pulse, 0);
    reset = 1'b0;

    // Three-entry one-shot sequence
    tick_en = 1'b1;
    cfg(0, 3); cfg(1, 1); cfg(2, 2);
    cfg_last = 2; loop_en = 1'b0;
    go();
    wait_n(9);
    chk("s1_npulse", pulse_q.size(), 3);
    chk("s1_p0", pq(0), 3);
    chk("s1_p1", pq(1), 4);
    chk("s1_p2", pq(2), 6);
    chk("s1_done", (done_q.size() == 1) ? done_q[0] : -1, 6);
    chk("s1_busy", busy, 0);

    // Zero entry means 2^PW ticks
    do_reset();
    cfg_last = 0;
    go();
    chk("s2_rem16", remaining, 16);
    wait_n(18);
    chk("s2_npulse", pulse_q.size(), 1);
    chk("s2_p0", pq(0), 16);

    // Looping, then loop_en dropped
    do_reset();
    cfg(0, 2); cfg(1, 2);
    cfg_last = 1; loop_en = 1'b1;
    go();
    wait_n(3);
    chk("s3_idx", cur_index, 1);
    wait_n(4);
    loop_en = 1'b0;
    wait_n(4);
    chk("s3_npulse", pulse_q.size(), 4);
    chk("s3_p3", pq(3), 8);
    chk("s3_done", (done_q.size() == 1) ? done_q[0] : -1, 8);

    // Pause and stop
    do_reset();
    cfg(0, 5);
    cfg_last = 0;
    go();
    wait_n(2);
    chk("s4_rem", remaining, 3);
    pause = 1'b1;
    wait_n(3);
    chk("s4_paused", paused, 1);
    chk("s4_frozen", remaining, 3);
    pause = 1'b0;
    wait_n(6);
    chk("s4_npulse", pulse_q.size(), 1);
    chk("s4_p0", pq(0), 9);
    go();
    wait_n(2);
    pause = 1'b1;
    wait_n(2);
    chk("s4_paused2", paused, 1);
    stop = 1'b1; pause = 1'b0;
    wait_n(1);
    stop = 1'b0;
    chk("s4_stop_busy", busy, 0);
    wait_n(8);
    chk("s4_nopulse", pulse_q.size(), 0);

    // Sparse ticks
    do_reset();
    tick_en = 1'b0;
    cfg(0, 2);
    go();
    for (int k = 0; k < 10; k++) begin
      tick_en = (k % 3 == 2);
      @(negedge clk);
    end
    tick_en = 1'b1;
    chk("s5_npulse", pulse_q.size(), 1);
    chk("s5_p0", pq(0), 6);

    // start+stop together in IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("s6_ss_busy", busy, 0);

    // start while running is ignored
    cfg(0, 5);
    go();
    wait_n(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_n(5);
    chk("s6_npulse", pulse_q.size(), 1);
    chk("s6_p0", pq(0), 5);

    // Write on the load edge returns old entry
    cfg(0, 2); cfg(1, 3);
    cfg_last = 1;
    go();
    wait_n(1);
    cfg_we = 1'b1; cfg_addr = 1; cfg_data = 7;
    @(negedge clk);
    cfg_we = 1'b0;
    chk("s6_old_rem", remaining, 3);
    chk("s6_old_idx", cur_index, 1);
    wait_n(6);
    chk("s6_rbw_n", pulse_q.size(), 2);
    chk("s6_rbw_p1", pq(1), 5);

    // Reset mid-run clears table
    cfg(0, 5);
    cfg_last = 0;
    go();
    wait_n(3);
    do_reset();
    chk("s7_busy", busy, 0);
    chk("s7_rem", remaining, 0);
    chk("s7_idx", cur_index, 0);
    chk("s7_pulse", out_pulse, 0);
    go();
    chk("s7_rem16", remaining, 16);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_n(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

endmodule
